ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/sys_defs.sv | 19 +
 rtl/ifetch_ibuf.sv | 77 +++++++
 rtl/ifetch_queue.sv | 143 ++++++++++++++
 tb/tb_ifetch_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared processor definitions: data width, ifetch parameter defaults and the
// IF->ID packet handed from the fetch queue to decode.
package sys_defs;

    localparam int unsigned XLEN = 32;

    localparam int unsigned     FETCH_WIDTH_DEF = 2;
    localparam int unsigned     IBUF_DEPTH_DEF  = 8;
    localparam logic [XLEN-1:0] RESET_PC_DEF    = XLEN'(0);

    // One fetched instruction with its address and fall-through address
    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
        logic            valid;
    } IF_ID_PACKET;

endpackage

// File: rtl/ifetch_ibuf.sv
// Instruction buffer: circular FIFO accepting up to FETCH_WIDTH entries and
// releasing up to FETCH_WIDTH entries per cycle.
// Ports:
//   clock_i, reset_i  - clock, synchronous active-high reset
//   flush_i           - empty the buffer at the next edge (ignores enq/deq)
//   enq_cnt_i         - number of enq_data_i slots to append (caller bounds to space)
//   enq_data_i        - entries to append, slot 0 first
//   deq_cnt_i         - number of head entries to drop (caller bounds to count)
//   head_data_o       - raw entries at head, head_data_o[0] is the oldest
//   count_o           - current occupancy
module ifetch_ibuf
    import sys_defs::*;
#(
    parameter int unsigned  FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int unsigned  IBUF_DEPTH  = IBUF_DEPTH_DEF,
    localparam int unsigned PTR_W       = $clog2(IBUF_DEPTH),
    localparam int unsigned CNT_W       = $clog2(IBUF_DEPTH + 1),
    localparam int unsigned FC_W        = $clog2(FETCH_WIDTH + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic [FC_W-1:0]   enq_cnt_i,
    input  IF_ID_PACKET       enq_data_i  [FETCH_WIDTH],
    input  logic [FC_W-1:0]   deq_cnt_i,
    output IF_ID_PACKET       head_data_o [FETCH_WIDTH],
    output logic [CNT_W-1:0]  count_o
);

    IF_ID_PACKET       mem_q [IBUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Pointer/occupancy update; pointers wrap naturally at PTR_W bits
    always_comb begin
        head_d  = head_q + PTR_W'(deq_cnt_i);
        tail_d  = tail_q + PTR_W'(enq_cnt_i);
        count_d = count_q + CNT_W'(enq_cnt_i) - CNT_W'(deq_cnt_i);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; unoccupied slots are masked by the consumer
    always_ff @(posedge clock_i) begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            if (!reset_i && !flush_i && (FC_W'(i) < enq_cnt_i)) begin
                mem_q[tail_q + PTR_W'(i)] <= enq_data_i[i];
            end
        end
    end

    // Head window read
    always_comb begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            head_data_o[i] = mem_q[head_q + PTR_W'(i)];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage with a decoupling queue: holds the PC, arbitrates
// redirects, picks instruction words out of the 64-bit icache block and
// buffers them for decode.
// Ports:
//   clock, reset                        - clock, synchronous active-high reset
//   if_valid                            - fetch enable (dequeue unaffected)
//   certain_branch_pc/_req              - resolved taken branch from EX (flushes)
//   rob_target_pc/_req                  - ROB recovery (flushes)
//   branch_pred_pc/_req                 - predictor redirect (keeps buffer)
//   Icache2proc_data/_valid             - block and hit for proc2Icache_addr
//   dispatch_count                      - head entries consumed this cycle
//   proc2Icache_addr                    - 8-byte aligned fetch address
//   if_packet                           - buffer head, slot 0 oldest
//   PC_reg_debug, count_debug           - current PC and buffer occupancy
module ifetch_queue
    import sys_defs::*;
#(
    parameter int unsigned     FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int unsigned     IBUF_DEPTH  = IBUF_DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEF,
    localparam int unsigned    CNT_W       = $clog2(IBUF_DEPTH + 1),
    localparam int unsigned    FC_W        = $clog2(FETCH_WIDTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   certain_branch_pc,
    input  logic              certain_branch_req,
    input  logic [XLEN-1:0]   rob_target_pc,
    input  logic              rob_target_req,
    input  logic [XLEN-1:0]   branch_pred_pc,
    input  logic              branch_pred_req,
    input  logic [63:0]       Icache2proc_data,
    input  logic              Icache2proc_data_valid,
    input  logic [FC_W-1:0]   dispatch_count,
    output logic [XLEN-1:0]   proc2Icache_addr,
    output IF_ID_PACKET       if_packet [FETCH_WIDTH],
    output logic [XLEN-1:0]   PC_reg_debug,
    output logic [CNT_W-1:0]  count_debug
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count;
    logic             flush;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] space;
    logic [FC_W-1:0]  cand;
    logic [FC_W-1:0]  enq_cnt;
    logic [FC_W-1:0]  valid_slots;
    logic [FC_W-1:0]  deq_cnt;
    IF_ID_PACKET      enq_data [FETCH_WIDTH];
    IF_ID_PACKET      head_raw [FETCH_WIDTH];

    // Redirect arbitration: certain > ROB > predictor, target word-aligned
    always_comb begin
        flush       = certain_branch_req | rob_target_req;
        redirect    = flush | branch_pred_req;
        redirect_pc = branch_pred_pc;
        if (certain_branch_req) begin
            redirect_pc = certain_branch_pc;
        end else if (rob_target_req) begin
            redirect_pc = rob_target_pc;
        end
        redirect_pc[1:0] = 2'b00;
    end

    // Enqueue/dequeue sizing; space is measured before this cycle's dequeue
    always_comb begin
        space = CNT_W'(IBUF_DEPTH) - count;
        cand  = '0;
        if (!redirect && if_valid && Icache2proc_data_valid) begin
            // An odd-word PC can only use the upper half of the block
            cand = pc_q[2] ? FC_W'(1) : FC_W'(FETCH_WIDTH);
        end
        enq_cnt = (CNT_W'(cand) > space) ? FC_W'(space) : cand;

        valid_slots = (count < CNT_W'(FETCH_WIDTH)) ? FC_W'(count) : FC_W'(FETCH_WIDTH);
        deq_cnt     = (dispatch_count > valid_slots) ? valid_slots : dispatch_count;
        if (flush) begin
            deq_cnt = '0;
        end
    end

    // Word selection: slot 0 takes the word PC points at, slot 1 the high word
    always_comb begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            enq_data[i]       = '0;
            enq_data[i].PC    = pc_q + XLEN'(4 * i);
            enq_data[i].NPC   = pc_q + XLEN'(4 * i + 4);
            enq_data[i].inst  = (i == 0 && !pc_q[2]) ? Icache2proc_data[31:0]
                                                     : Icache2proc_data[63:32];
            enq_data[i].valid = 1'b1;
        end
    end

    // Next PC: redirect target, else advance past what was accepted
    always_comb begin
        pc_d = pc_q + (XLEN'(enq_cnt) << 2);
        if (redirect) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ifetch_ibuf #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .IBUF_DEPTH  (IBUF_DEPTH)
    ) u_ibuf (
        .clock_i     (clock),
        .reset_i     (reset),
        .flush_i     (flush),
        .enq_cnt_i   (enq_cnt),
        .enq_data_i  (enq_data),
        .deq_cnt_i   (deq_cnt),
        .head_data_o (head_raw),
        .count_o     (count)
    );

    // Present occupied head slots; empty slots read as all-zero
    always_comb begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            if (CNT_W'(i) < count) begin
                if_packet[i]       = head_raw[i];
                if_packet[i].valid = 1'b1;
            end else begin
                if_packet[i] = '0;
            end
        end
    end

    assign proc2Icache_addr = {pc_q[XLEN-1:3], 3'b000};
    assign PC_reg_debug     = pc_q;
    assign count_debug      = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_ifetch_queue;
    import sys_defs::*;

    localparam int unsigned FW    = 2;
    localparam int unsigned DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] certain_branch_pc;
    logic        certain_branch_req;
    logic [31:0] rob_target_pc;
    logic        rob_target_req;
    logic [31:0] branch_pred_pc;
    logic        branch_pred_req;
    logic [63:0] Icache2proc_data;
    logic        Icache2proc_data_valid;
    logic [1:0]  dispatch_count;
    logic [31:0] proc2Icache_addr;
    IF_ID_PACKET if_packet [FW];
    logic [31:0] PC_reg_debug;
    logic [3:0]  count_debug;

    ifetch_queue #(
        .FETCH_WIDTH (FW),
        .IBUF_DEPTH  (DEPTH),
        .RESET_PC    (32'h0)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .if_valid               (if_valid),
        .certain_branch_pc      (certain_branch_pc),
        .certain_branch_req     (certain_branch_req),
        .rob_target_pc          (rob_target_pc),
        .rob_target_req         (rob_target_req),
        .branch_pred_pc         (branch_pred_pc),
        .branch_pred_req        (branch_pred_req),
        .Icache2proc_data       (Icache2proc_data),
        .Icache2proc_data_valid (Icache2proc_data_valid),
        .dispatch_count         (dispatch_count),
        .proc2Icache_addr       (proc2Icache_addr),
        .if_packet              (if_packet),
        .PC_reg_debug           (PC_reg_debug),
        .count_debug            (count_debug)
    );

    always #5 clock = ~clock;

    // Reference model: fetch PC plus an ordered list of buffered instructions
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        hit;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Memory image: every word address maps to a distinct pseudo-random word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        IF_ID_PACKET exp;
        chk("proc2Icache_addr", 128'(proc2Icache_addr), 128'({m_pc[31:3], 3'b000}));
        chk("PC_reg_debug", 128'(PC_reg_debug), 128'(m_pc));
        chk("count_debug", 128'(count_debug), 128'(mq.size()));
        for (int i = 0; i < int'(FW); i++) begin
            exp = '0;
            if (i < mq.size()) begin
                exp.inst  = mq[i].inst;
                exp.PC    = mq[i].pc;
                exp.NPC   = mq[i].pc + 32'd4;
                exp.valid = 1'b1;
            end
            chk($sformatf("if_packet[%0d]", i), 128'(if_packet[i]), 128'(exp));
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        int          deq;
        int          enq;
        int          cand;
        int          sp;
        logic [31:0] a;
        if (reset) begin
            m_pc = 32'h0;
            mq.delete();
            return;
        end
        if (certain_branch_req || rob_target_req) begin
            a    = certain_branch_req ? certain_branch_pc : rob_target_pc;
            m_pc = a & ~32'h3;
            mq.delete();
            return;
        end
        deq = int'(dispatch_count);
        if (deq > mq.size()) deq = mq.size();
        if (deq > int'(FW))  deq = int'(FW);
        enq = 0;
        if (!branch_pred_req && if_valid && hit) begin
            cand = m_pc[2] ? 1 : int'(FW);
            sp   = int'(DEPTH) - mq.size();
            enq  = (cand < sp) ? cand : sp;
        end
        for (int k = 0; k < enq; k++) begin
            a = m_pc + 32'(4 * k);
            mq.push_back('{mem_word(a), a});
        end
        repeat (deq) void'(mq.pop_front());
        if (branch_pred_req) m_pc = branch_pred_pc & ~32'h3;
        else                 m_pc = m_pc + 32'(4 * enq);
    endtask

    // Serve the icache from the model's PC, take one edge, compare everything
    task automatic cycle();
        logic [31:0] blk;
        blk = {m_pc[31:3], 3'b000};
        if (hit) Icache2proc_data = {mem_word(blk + 32'd4), mem_word(blk)};
        else     Icache2proc_data = {$urandom, $urandom};
        Icache2proc_data_valid = hit;
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic clear_reqs();
        certain_branch_req = 1'b0;
        rob_target_req     = 1'b0;
        branch_pred_req    = 1'b0;
    endtask

    function automatic logic [31:0] rand_tgt();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        reset              = 1'b1;
        if_valid           = 1'b0;
        hit                = 1'b0;
        dispatch_count     = 2'd0;
        certain_branch_pc  = 32'h0;
        rob_target_pc      = 32'h0;
        branch_pred_pc     = 32'h0;
        Icache2proc_data   = 64'h0;
        Icache2proc_data_valid = 1'b0;
        clear_reqs();
        m_pc = 32'h0;
        @(negedge clock);

        // Streaming with full dispatch
        cycle();
        reset = 1'b0; if_valid = 1'b1; hit = 1'b1; dispatch_count = 2'd2;
        cycle();
        chk("stream_pc0", 128'(if_packet[0].PC), 128'(32'h0));
        chk("stream_pc1", 128'(if_packet[1].PC), 128'(32'h4));
        cycle();
        chk("stream_pc2", 128'(if_packet[0].PC), 128'(32'h8));
        chk("stream_pc3", 128'(if_packet[1].PC), 128'(32'hC));
        chk("stream_count", 128'(count_debug), 128'(4'd2));
        repeat (4) cycle();

        // Fill with no dispatch
        reset = 1'b1; cycle(); reset = 1'b0;
        dispatch_count = 2'd0;
        repeat (6) cycle();
        chk("full_count", 128'(count_debug), 128'(4'd8));
        chk("full_pc", 128'(PC_reg_debug), 128'(32'h20));
        chk("full_addr", 128'(proc2Icache_addr), 128'(32'h20));

        // Certain branch beats predictor in the same cycle
        certain_branch_req = 1'b1; certain_branch_pc = 32'h100;
        branch_pred_req    = 1'b1; branch_pred_pc    = 32'h200;
        cycle();
        clear_reqs();
        chk("flush_count", 128'(count_debug), 128'(4'd0));
        chk("flush_pc", 128'(PC_reg_debug), 128'(32'h100));

        // Predictor redirect with 3 buffered entries
        cycle();
        dispatch_count = 2'd1;
        cycle();
        dispatch_count = 2'd0;
        branch_pred_req = 1'b1; branch_pred_pc = 32'h206;
        cycle();
        clear_reqs();
        chk("pred_count", 128'(count_debug), 128'(4'd3));
        chk("pred_pc", 128'(PC_reg_debug), 128'(32'h204));
        chk("pred_head", 128'(if_packet[0].PC), 128'(32'h104));
        cycle();
        chk("pred_enq_count", 128'(count_debug), 128'(4'd4));
        chk("pred_next_pc", 128'(PC_reg_debug), 128'(32'h208));

        // Icache miss holds the fetch address
        rob_target_req = 1'b1; rob_target_pc = 32'h40;
        cycle();
        clear_reqs();
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("miss_addr", 128'(proc2Icache_addr), 128'(32'h40));
            chk("miss_count", 128'(count_debug), 128'(4'd0));
        end
        hit = 1'b1;
        cycle();
        chk("miss_resume_count", 128'(count_debug), 128'(4'd2));
        chk("miss_resume_pc", 128'(if_packet[0].PC), 128'(32'h40));

        // Reset with 5 entries buffered
        dispatch_count = 2'd1;
        cycle();
        dispatch_count = 2'd0;
        cycle();
        chk("pre_reset_count", 128'(count_debug), 128'(4'd5));
        reset = 1'b1; certain_branch_req = 1'b1; certain_branch_pc = 32'h300;
        cycle();
        chk("rst_count", 128'(count_debug), 128'(4'd0));
        chk("rst_valid0", 128'(if_packet[0].valid), 128'(1'b0));
        chk("rst_valid1", 128'(if_packet[1].valid), 128'(1'b0));
        chk("rst_pc", 128'(PC_reg_debug), 128'(32'h0));
        reset = 1'b0; clear_reqs();
        cycle();
        chk("post_rst_fetch", 128'(if_packet[0].PC), 128'(32'h0));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset              = ($urandom_range(0, 99) == 0);
            if_valid           = ($urandom_range(0, 3) != 0);
            hit                = ($urandom_range(0, 3) != 0);
            dispatch_count     = 2'($urandom_range(0, 3));
            certain_branch_req = ($urandom_range(0, 19) == 0);
            rob_target_req     = ($urandom_range(0, 19) == 0);
            branch_pred_req    = ($urandom_range(0, 7) == 0);
            certain_branch_pc  = rand_tgt();
            rob_target_pc      = rand_tgt();
            branch_pred_pc     = rand_tgt();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
